// File: rtl/hack_pkg.sv
// Shared definitions for the Hack memory arbiter slice.
//   HACK_AW / HACK_DW : default word address / data widths of the Hack data memory
//   arb_state_t       : arbiter FSM encoding (ST_ARB, ST_LOCK1)
//   M_CPU / M_SCAN    : master indices into the per-master packed arrays
package hack_pkg;
    localparam int HACK_AW = 15;
    localparam int HACK_DW = 16;
    localparam int NUM_M   = 2;
    localparam int M_CPU   = 0;
    localparam int M_SCAN  = 1;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_LOCK1 = 1'b1
    } arb_state_t;
endpackage

// File: rtl/hack_rr_pick2.sv
// Combinational 2-way round-robin picker.
//   req[1:0]   : request vector
//   last       : index of the master granted most recently
//   grant[1:0] : one-hot grant (or zero when nobody requests)
// On a tie the master that was NOT granted last wins.
module hack_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/hack_mem_arbiter.sv
// Two-master arbiter in front of the single-port Hack data memory.
// Master 0 = CPU data port, master 1 = display scanout (may lock for bursts).
//   clk, rst_n            : clock, asynchronous active-low reset
//   mX_req/we/addr/wdata  : master request, held until mX_gnt
//   mX_gnt                : combinational accept, at most one per cycle
//   mX_rvalid/mX_rdata    : read return, exactly one cycle after the grant
//   m1_lock               : scanout burst lock, sampled with m1_req
//   mem_addr/we/wdata     : to the memory-map mux (zero when idle)
//   mem_rdata             : memory read data, one cycle after the address
// Optional (macro ARB_STATS_EN): stat_clr input and saturating 16-bit
// counters stat_m0_gnts, stat_m1_gnts, stat_conflicts.
module hack_mem_arbiter
    import hack_pkg::*;
#(
    parameter int AW        = HACK_AW,
    parameter int DW        = HACK_DW,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef ARB_STATS_EN
    input  logic          stat_clr,
    output logic [15:0]   stat_m0_gnts,
    output logic [15:0]   stat_m1_gnts,
    output logic [15:0]   stat_conflicts,
`endif
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [7:0] MAXB = 8'(MAX_BURST);

    logic [NUM_M-1:0]         req, we;
    logic [NUM_M-1:0][AW-1:0] addr;
    logic [NUM_M-1:0][DW-1:0] wdata;

    assign req   = {m1_req, m0_req};
    assign we    = {m1_we, m0_we};
    assign addr  = {m1_addr, m0_addr};
    assign wdata = {m1_wdata, m0_wdata};

    arb_state_t       state, state_nx;
    logic             last, last_nx;
    logic [7:0]       cnt, cnt_nx;
    logic [NUM_M-1:0] rr_gnt, gnt, g;
    logic             burst_go, exhausted;

    hack_rr_pick2 u_pick (
        .req   (req),
        .last  (last),
        .grant (rr_gnt)
    );

    assign burst_go  = (state == ST_LOCK1) && m1_req && m1_lock && (cnt < MAXB);
    assign exhausted = (state == ST_LOCK1) && (cnt == MAXB);

    always_comb begin
        gnt      = '0;
        state_nx = state;
        last_nx  = last;
        cnt_nx   = cnt;
        if (burst_go) begin
            gnt    = 2'b10;
            cnt_nx = cnt + 8'd1;
        end else begin
            // ARB, or the LOCK1 exit cycle which behaves as ARB; a burst that
            // ran out hands the slot to a waiting CPU regardless of last.
            state_nx = ST_ARB;
            cnt_nx   = '0;
            gnt      = (exhausted && m0_req) ? 2'b01 : rr_gnt;
            if (gnt[M_SCAN] && m1_lock) begin
                state_nx = ST_LOCK1;
                cnt_nx   = 8'd1;
            end
        end
        if (|gnt)
            last_nx = gnt[M_SCAN];
    end

    // Grants are combinational, so hold them off while reset is asserted.
    assign g = gnt & {NUM_M{rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ARB;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (g[i]) begin
                mem_addr  = addr[i];
                mem_we    = we[i];
                mem_wdata = wdata[i];
            end
        end
    end

    // Read return: valid one cycle behind the grant. Data passes straight
    // from the memory in the valid cycle and is held afterwards.
    logic [NUM_M-1:0]         rvld_q;
    logic [NUM_M-1:0][DW-1:0] rdata_q, rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvld_q  <= '0;
            rdata_q <= '0;
        end else begin
            rvld_q <= g & ~we;
            for (int i = 0; i < NUM_M; i++)
                if (rvld_q[i]) rdata_q[i] <= mem_rdata;
        end
    end

    for (genvar i = 0; i < NUM_M; i++) begin : g_rd
        assign rdata[i] = rvld_q[i] ? mem_rdata : rdata_q[i];
    end

    assign m0_gnt    = g[M_CPU];
    assign m1_gnt    = g[M_SCAN];
    assign m0_rvalid = rvld_q[M_CPU];
    assign m1_rvalid = rvld_q[M_SCAN];
    assign m0_rdata  = rdata[M_CPU];
    assign m1_rdata  = rdata[M_SCAN];

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_m0_gnts   <= '0;
            stat_m1_gnts   <= '0;
            stat_conflicts <= '0;
        end else if (stat_clr) begin
            stat_m0_gnts   <= '0;
            stat_m1_gnts   <= '0;
            stat_conflicts <= '0;
        end else begin
            if (g[M_CPU] && stat_m0_gnts != 16'hFFFF)
                stat_m0_gnts <= stat_m0_gnts + 16'd1;
            if (g[M_SCAN] && stat_m1_gnts != 16'hFFFF)
                stat_m1_gnts <= stat_m1_gnts + 16'd1;
            if ((&req) && stat_conflicts != 16'hFFFF)
                stat_conflicts <= stat_conflicts + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hack_mem_arbiter.sv
module tb_hack_mem_arbiter;
    localparam int AW = 15;
    localparam int DW = 16;
    localparam int MAX_BURST = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 0, m0_we = 0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    hack_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // memory device: synchronous read, one cycle latency
    logic [DW-1:0] dev_mem [0:32767];
    always @(posedge clk) begin
        if (mem_we) dev_mem[mem_addr] <= mem_wdata;
        mem_rdata <= dev_mem[mem_addr];
    end

    // reference model state
    logic [DW-1:0] ref_mem [0:32767];
    bit            m_locked;
    int            m_burst;
    int            m_last;
    bit [1:0]      exp_rv;
    logic [DW-1:0] exp_rd [2];

    logic [1:0]    obs_g, obs_rv;
    logic          obs_we;
    logic [DW-1:0] obs_rd0, obs_rd1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked  = 0;
        m_burst   = 0;
        m_last    = 1;
        exp_rv    = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // One arbitration cycle: check at negedge, advance model, return at posedge+1.
    task automatic step(input string tag);
        int pick;
        bit cont;
        @(negedge clk);
        // scanout keeps the memory while it holds lock and the burst has room
        cont = m_locked && m1_req && m1_lock && (m_burst < MAX_BURST);
        if (cont) pick = 1;
        else if (m0_req && m1_req)
            pick = (m_locked && m_burst == MAX_BURST) ? 0 : (m_last == 1 ? 0 : 1);
        else if (m0_req) pick = 0;
        else if (m1_req) pick = 1;
        else pick = -1;

        obs_g = {m1_gnt, m0_gnt};  obs_rv = {m1_rvalid, m0_rvalid};
        obs_we = mem_we;  obs_rd0 = m0_rdata;  obs_rd1 = m1_rdata;

        chk({tag, "/m0_gnt"}, 32'(m0_gnt), 32'(pick == 0));
        chk({tag, "/m1_gnt"}, 32'(m1_gnt), 32'(pick == 1));
        chk({tag, "/mem_we"}, 32'(mem_we),
            32'((pick == 0 && m0_we) || (pick == 1 && m1_we)));
        chk({tag, "/mem_addr"}, 32'(mem_addr),
            pick == 0 ? 32'(m0_addr) : pick == 1 ? 32'(m1_addr) : 32'd0);
        if ((pick == 0 && m0_we) || (pick == 1 && m1_we))
            chk({tag, "/mem_wdata"}, 32'(mem_wdata), pick == 0 ? 32'(m0_wdata) : 32'(m1_wdata));
        chk({tag, "/m0_rvalid"}, 32'(m0_rvalid), 32'(exp_rv[0]));
        chk({tag, "/m1_rvalid"}, 32'(m1_rvalid), 32'(exp_rv[1]));
        chk({tag, "/m0_rdata"}, 32'(m0_rdata), 32'(exp_rd[0]));
        chk({tag, "/m1_rdata"}, 32'(m1_rdata), 32'(exp_rd[1]));

        exp_rv = '0;
        if (pick == 0) begin
            if (m0_we) ref_mem[m0_addr] = m0_wdata;
            else begin exp_rv[0] = 1; exp_rd[0] = ref_mem[m0_addr]; end
        end else if (pick == 1) begin
            if (m1_we) ref_mem[m1_addr] = m1_wdata;
            else begin exp_rv[1] = 1; exp_rd[1] = ref_mem[m1_addr]; end
        end
        if (cont) m_burst++;
        else if (pick == 1 && m1_lock) begin m_locked = 1; m_burst = 1; end
        else begin m_locked = 0; m_burst = 0; end
        if (pick >= 0) m_last = pick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/gnt"}, 32'({m1_gnt, m0_gnt}), 32'd0);
        chk({tag, "/rvalid"}, 32'({m1_rvalid, m0_rvalid}), 32'd0);
        chk({tag, "/mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "/mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "/m0_rdata"}, 32'(m0_rdata), 32'd0);
        chk({tag, "/m1_rdata"}, 32'(m1_rdata), 32'd0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 15'h0010;
            1:       return 15'h4000 | 15'($urandom_range(0, 15));
            2:       return 15'h6000;
            default: return 15'($urandom_range(0, 15));
        endcase
    endfunction

    // Masters hold a pending request until granted (occasionally withdrawing).
    task automatic drive_rand();
        if (m0_req && !obs_g[0]) begin
            if ($urandom_range(0, 19) == 0) m0_req = 0;
        end else begin
            m0_req   = ($urandom_range(0, 99) < 60);
            m0_we    = ($urandom_range(0, 2) == 0);
            m0_addr  = rand_addr();
            m0_wdata = 16'($urandom);
        end
        if (m1_req && !obs_g[1]) begin
            if ($urandom_range(0, 19) == 0) m1_req = 0;
        end else begin
            m1_req   = ($urandom_range(0, 99) < 70);
            m1_we    = ($urandom_range(0, 3) == 0);
            m1_lock  = ($urandom_range(0, 3) != 0);
            m1_addr  = rand_addr();
            m1_wdata = 16'($urandom);
        end
    endtask

    task automatic idle();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m1_lock = 0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            dev_mem[i] = '0;
            ref_mem[i] = '0;
        end
        dev_mem[15'h0010] = 16'hBEEF;
        ref_mem[15'h0010] = 16'hBEEF;
        model_reset();

        // reset state
        #12;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1;

        // A: single CPU read
        m0_req = 1; m0_we = 0; m0_addr = 15'h0010;
        step("A0");
        chk("A_gnt", 32'(obs_g), 32'd1);
        idle();
        step("A1");
        chk("A_rvalid", 32'(obs_rv), 32'd1);
        chk("A_rdata", 32'(obs_rd0), 32'hBEEF);
        chk("A_m1_rdata", 32'(obs_rd1), 32'd0);

        // B: continuous contention alternates starting with m0
        rst_n = 0; #1; rst_n = 1; model_reset();
        m0_req = 1; m0_addr = 15'h0010; m1_req = 1; m1_addr = 15'h0011;
        for (int k = 0; k < 6; k++) begin
            step("B");
            chk("B_alt", 32'(obs_g), (k % 2 == 0) ? 32'd1 : 32'd2);
        end

        // C: locked burst of MAX_BURST, then m0, then m1 again
        m1_req = 0;
        step("C_pre");                     // m0 alone -> last = m0
        m1_req = 1; m1_lock = 1; m1_addr = 15'h4000;
        for (int k = 0; k < 10; k++) begin
            step("C");
            chk("C_seq", 32'(obs_g), (k < MAX_BURST || k == MAX_BURST + 1) ? 32'd2 : 32'd1);
            if (obs_g[1]) m1_addr = m1_addr + 15'd1;
        end
        m1_req = 0;
        step("C_exit");
        chk("C_exit_gnt", 32'(obs_g), 32'd1);
        idle();
        step("C_idle");

        // D: lock dropped after 3 beats while m0 waits
        m0_req = 1; step("D_pre");        // last = m0
        m1_req = 1; m1_lock = 1; m1_addr = 15'h4010;
        for (int k = 0; k < 3; k++) begin
            step("D");
            chk("D_burst", 32'(obs_g), 32'd2);
        end
        m1_lock = 0;
        step("D_drop");
        chk("D_drop_gnt", 32'(obs_g), 32'd1);
        idle();
        step("D_idle");

        // E: write/read race on 0x6000, m0 goes first because m1 was last
        m1_req = 1; m1_addr = 15'h0020;
        step("E_pre");
        m0_req = 1; m0_we = 1; m0_addr = 15'h6000; m0_wdata = 16'h1234;
        m1_req = 1; m1_we = 0; m1_addr = 15'h6000;
        step("E0");
        chk("E_wr_gnt", 32'(obs_g), 32'd1);
        chk("E_wr_we", 32'(obs_we), 32'd1);
        m0_req = 0; m0_we = 0;
        step("E1");
        chk("E_rd_gnt", 32'(obs_g), 32'd2);
        chk("E_rd_we", 32'(obs_we), 32'd0);
        m1_req = 0;
        step("E2");
        chk("E_rd_data", 32'(obs_rd1), 32'h1234);

        // F: reset in the middle of a locked burst with a read in flight
        m1_req = 1; m1_lock = 1; m1_addr = 15'h4100;
        step("F0");
        step("F1");
        rst_n = 0;
        #1;
        chk_reset_outputs("F_rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        m0_req = 1; m0_addr = 15'h0010; m1_lock = 0;
        step("F2");
        chk("F_after_gnt", 32'(obs_g), 32'd1);
        idle();
        step("F_idle");

        // random traffic against the model
        obs_g = '0;
        for (int k = 0; k < 3000; k++) begin
            drive_rand();
            step("R");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
